// File: rtl/ptr_sync_gen.sv
// ptr_sync_gen: gray-code pointer synchroniser with binary decode, advance delta and change pulse.
// Define GRAY_CHECK_EN to build the sticky multi-bit gray transition checker.
module ptr_sync_gen #(
    parameter int SIZE   = 4,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] bin_ptr_in,
    input  logic            err_clr,
    output logic [SIZE-1:0] sync_gray_ptr_out,
    output logic [SIZE-1:0] sync_bin_ptr_out,
    output logic [SIZE-1:0] ptr_delta,
    output logic            ptr_changed,
    output logic            err_multi_bit
);
    logic [SIZE-1:0] gray_q;
    logic [SIZE-1:0] s [1:STAGES];
    logic [SIZE-1:0] dec;

    assign sync_gray_ptr_out = s[STAGES];

    // Each binary bit is the parity of the gray bits at and above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < SIZE; i++) dec[i] = ^(sync_gray_ptr_out >> i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
            for (int k = 1; k <= STAGES; k++) s[k] <= '0;
            sync_bin_ptr_out <= '0;
            ptr_delta <= '0;
            ptr_changed <= 1'b0;
        end else begin
            gray_q <= bin_ptr_in ^ (bin_ptr_in >> 1);
            s[1] <= gray_q;
            for (int k = 2; k <= STAGES; k++) s[k] <= s[k-1];
            sync_bin_ptr_out <= dec;
            ptr_delta <= dec - sync_bin_ptr_out;
            ptr_changed <= dec != sync_bin_ptr_out;
        end
    end

`ifdef GRAY_CHECK_EN
    logic [SIZE-1:0] prev_gray;
    logic            multi;

    assign multi = $countones(sync_gray_ptr_out ^ prev_gray) > 1;

    // A new violation outranks a clear arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            err_multi_bit <= 1'b0;
        end else begin
            prev_gray <= sync_gray_ptr_out;
            err_multi_bit <= multi | (err_multi_bit & ~err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_multi_bit = 1'b0;
`endif
endmodule
